// File: rtl/elastic_register_pipe_if.sv
// Valid/ready payload channel used on both sides of the elastic register pipe.
// The producer drives data/valid and the consumer drives ready.
interface elastic_register_pipe_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/elastic_register_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse,
// flush, and a registered occupancy count. DEPTH=0 degenerates to a wire.
module elastic_register_pipe #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 2,
  parameter bit RESET_DATA = 1'b0,
  localparam int CW        = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  elastic_register_pipe_if.slave   up_if,
  elastic_register_pipe_if.master  dn_if,
  output logic [CW-1:0]            occupancy_o
);

  generate
    if (DEPTH == 0) begin : g_pass

      assign dn_if.data  = up_if.data;
      assign dn_if.valid = up_if.valid & ~flush_i;
      assign up_if.ready = dn_if.ready & ~flush_i;
      assign occupancy_o = '0;

    end else begin : g_pipe

      logic [DEPTH-1:0][WIDTH-1:0] data_q;
      logic [DEPTH-1:0][WIDTH-1:0] data_d;
      logic [DEPTH-1:0][WIDTH-1:0] in_data_s;
      logic [DEPTH-1:0]            valid_q;
      logic [DEPTH-1:0]            valid_d;
      logic [DEPTH-1:0]            in_valid_s;
      logic [DEPTH-1:0]            accept_s;
      logic [CW-1:0]               occ_q;
      logic [CW-1:0]               occ_d;
      logic                        acc_s;
      logic                        ready_in_s;
      logic                        in_xfer_s;
      logic                        out_xfer_s;

      // A stage can accept when it, or any stage downstream of it, is empty or draining.
      always_comb begin
        accept_s = '0;
        acc_s    = dn_if.ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
          acc_s       = acc_s | ~valid_q[i];
          accept_s[i] = acc_s;
        end
      end

      assign ready_in_s = accept_s[0] & ~flush_i;
      assign in_xfer_s  = up_if.valid & ready_in_s;
      assign out_xfer_s = valid_q[DEPTH-1] & dn_if.ready;

      always_comb begin
        in_data_s     = '0;
        in_valid_s    = '0;
        in_data_s[0]  = up_if.data;
        in_valid_s[0] = in_xfer_s;
        for (int i = 1; i < DEPTH; i++) begin
          in_data_s[i]  = data_q[i-1];
          in_valid_s[i] = valid_q[i-1];
        end
      end

      // Data only moves on a real payload so bubbles leave the registers quiet.
      always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        occ_d   = occ_q;
        for (int i = 0; i < DEPTH; i++) begin
          if (accept_s[i]) begin
            valid_d[i] = in_valid_s[i];
            if (in_valid_s[i]) begin
              data_d[i] = in_data_s[i];
            end else begin
              data_d[i] = data_q[i];
            end
          end else begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
          end
        end
        if (flush_i) begin
          valid_d = '0;
          occ_d   = '0;
        end else begin
          case ({in_xfer_s, out_xfer_s})
            2'b10:   occ_d = occ_q + CW'(1);
            2'b01:   occ_d = occ_q - CW'(1);
            default: occ_d = occ_q;
          endcase
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          valid_q <= '0;
          occ_q   <= '0;
        end else begin
          valid_q <= valid_d;
          occ_q   <= occ_d;
        end
      end

      always_ff @(posedge clk_i) begin
        if (rst_i && RESET_DATA) begin
          data_q <= '0;
        end else begin
          data_q <= data_d;
        end
      end

      assign dn_if.data  = data_q[DEPTH-1];
      assign dn_if.valid = valid_q[DEPTH-1];
      assign up_if.ready = ready_in_s;
      assign occupancy_o = occ_q;

    end
  endgenerate

endmodule

// File: tb/tb_elastic_register_pipe.sv
// Directed bench for elastic_register_pipe: DEPTH=3 with data reset, plus a
// DEPTH=0 pass-through instance.
module tb_elastic_register_pipe;

  logic       clk;
  logic       rst;
  logic       flush3;
  logic       flush0;
  logic [1:0] occ3;
  logic [0:0] occ0;
  int         errors;
  int         checks;

  elastic_register_pipe_if #(.WIDTH(8)) up3 ();
  elastic_register_pipe_if #(.WIDTH(8)) dn3 ();
  elastic_register_pipe_if #(.WIDTH(8)) up0 ();
  elastic_register_pipe_if #(.WIDTH(8)) dn0 ();

  elastic_register_pipe #(.WIDTH(8), .DEPTH(3), .RESET_DATA(1'b1)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush3),
    .up_if      (up3),
    .dn_if      (dn3),
    .occupancy_o(occ3)
  );

  elastic_register_pipe #(.WIDTH(8), .DEPTH(0), .RESET_DATA(1'b0)) u_dut0 (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush0),
    .up_if      (up0),
    .dn_if      (dn0),
    .occupancy_o(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    flush3     = 1'b0;
    flush0     = 1'b0;
    up3.data   = 8'h99;
    up3.valid  = 1'b1;
    dn3.ready  = 1'b0;
    up0.data   = 8'h00;
    up0.valid  = 1'b0;
    dn0.ready  = 1'b0;

    // Reset held two cycles with validIn asserted
    tick();
    tick();
    rst       = 1'b0;
    up3.valid = 1'b0;
    #1;
    chk("rst_validOut", 32'(dn3.valid), 32'd0);
    chk("rst_occ", 32'(occ3), 32'd0);
    chk("rst_readyIn", 32'(up3.ready), 32'd1);
    chk("rst_dataOut", 32'(dn3.data), 32'h00);

    // Stream 0x11,0x22,0x33 with readyOut=1
    dn3.ready = 1'b1;
    up3.valid = 1'b1;
    up3.data  = 8'h11;
    #1;
    chk("str_rdy0", 32'(up3.ready), 32'd1);
    chk("str_occ0", 32'(occ3), 32'd0);
    tick();
    up3.data = 8'h22;
    #1;
    chk("str_rdy1", 32'(up3.ready), 32'd1);
    chk("str_occ1", 32'(occ3), 32'd1);
    tick();
    up3.data = 8'h33;
    #1;
    chk("str_rdy2", 32'(up3.ready), 32'd1);
    chk("str_occ2", 32'(occ3), 32'd2);
    chk("str_vout2", 32'(dn3.valid), 32'd0);
    tick();
    up3.valid = 1'b0;
    #1;
    chk("str_vout3", 32'(dn3.valid), 32'd1);
    chk("str_dout3", 32'(dn3.data), 32'h11);
    chk("str_occ3", 32'(occ3), 32'd3);
    tick();
    chk("str_dout4", 32'(dn3.data), 32'h22);
    chk("str_occ4", 32'(occ3), 32'd2);
    tick();
    chk("str_dout5", 32'(dn3.data), 32'h33);
    chk("str_occ5", 32'(occ3), 32'd1);
    tick();
    chk("str_vout6", 32'(dn3.valid), 32'd0);
    chk("str_occ6", 32'(occ3), 32'd0);

    // Backpressure: fill with A0..A2, A3 stalls until readyOut rises
    dn3.ready = 1'b0;
    up3.valid = 1'b1;
    up3.data  = 8'hA0;
    #1;
    chk("bp_rdyA0", 32'(up3.ready), 32'd1);
    tick();
    up3.data = 8'hA1;
    #1;
    chk("bp_rdyA1", 32'(up3.ready), 32'd1);
    tick();
    up3.data = 8'hA2;
    #1;
    chk("bp_rdyA2", 32'(up3.ready), 32'd1);
    tick();
    up3.data = 8'hA3;
    #1;
    chk("bp_full_rdy", 32'(up3.ready), 32'd0);
    chk("bp_full_occ", 32'(occ3), 32'd3);
    chk("bp_full_dout", 32'(dn3.data), 32'hA0);
    tick();
    chk("bp_hold_occ", 32'(occ3), 32'd3);
    chk("bp_hold_dout", 32'(dn3.data), 32'hA0);
    dn3.ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(up3.ready), 32'd1);
    tick();
    up3.valid = 1'b0;
    #1;
    chk("bp_swap_occ", 32'(occ3), 32'd3);
    chk("bp_dout1", 32'(dn3.data), 32'hA1);
    tick();
    chk("bp_dout2", 32'(dn3.data), 32'hA2);
    chk("bp_occ2", 32'(occ3), 32'd2);
    tick();
    chk("bp_dout3", 32'(dn3.data), 32'hA3);
    chk("bp_occ1", 32'(occ3), 32'd1);
    tick();
    chk("bp_empty_v", 32'(dn3.valid), 32'd0);
    chk("bp_empty_occ", 32'(occ3), 32'd0);

    // Bubble collapse with readyOut held low
    dn3.ready = 1'b0;
    up3.valid = 1'b1;
    up3.data  = 8'h01;
    tick();
    up3.valid = 1'b0;
    tick();
    up3.valid = 1'b1;
    up3.data  = 8'h02;
    tick();
    up3.valid = 1'b0;
    tick();
    chk("bub_occ", 32'(occ3), 32'd2);
    chk("bub_vout", 32'(dn3.valid), 32'd1);
    chk("bub_dout", 32'(dn3.data), 32'h01);
    chk("bub_rdy", 32'(up3.ready), 32'd1);
    tick();
    chk("bub_stable_occ", 32'(occ3), 32'd2);
    dn3.ready = 1'b1;
    tick();
    chk("bub_next_v", 32'(dn3.valid), 32'd1);
    chk("bub_next_d", 32'(dn3.data), 32'h02);
    tick();
    chk("bub_drained", 32'(dn3.valid), 32'd0);

    // Flush with a simultaneous push of 0x55
    dn3.ready = 1'b0;
    up3.valid = 1'b1;
    up3.data  = 8'h61;
    tick();
    up3.data = 8'h62;
    tick();
    chk("fl_pre_occ", 32'(occ3), 32'd2);
    flush3   = 1'b1;
    up3.data = 8'h55;
    #1;
    chk("fl_rdy", 32'(up3.ready), 32'd0);
    tick();
    flush3    = 1'b0;
    up3.valid = 1'b0;
    #1;
    chk("fl_occ", 32'(occ3), 32'd0);
    chk("fl_vout", 32'(dn3.valid), 32'd0);
    dn3.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("fl_no55", 32'(dn3.valid), 32'd0);
    end

    // Reset mid-stream discards in-flight payloads
    dn3.ready = 1'b0;
    up3.valid = 1'b1;
    up3.data  = 8'h71;
    tick();
    up3.data = 8'h72;
    tick();
    up3.valid = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mr_occ", 32'(occ3), 32'd0);
    chk("mr_vout", 32'(dn3.valid), 32'd0);
    chk("mr_dout", 32'(dn3.data), 32'h00);
    dn3.ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_none", 32'(dn3.valid), 32'd0);
    end

    // DEPTH=0 pass-through
    up0.data  = 8'h3C;
    up0.valid = 1'b1;
    dn0.ready = 1'b0;
    #1;
    chk("d0_data", 32'(dn0.data), 32'h3C);
    chk("d0_valid", 32'(dn0.valid), 32'd1);
    chk("d0_rdy_low", 32'(up0.ready), 32'd0);
    chk("d0_occ", 32'(occ0), 32'd0);
    dn0.ready = 1'b1;
    #1;
    chk("d0_rdy_high", 32'(up0.ready), 32'd1);
    flush0 = 1'b1;
    #1;
    chk("d0_fl_valid", 32'(dn0.valid), 32'd0);
    chk("d0_fl_rdy", 32'(up0.ready), 32'd0);
    flush0 = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/elastic_register_pipe.md
ELASTIC_REGISTER_PIPE -- requirements
Module: elasticRegisterPipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload width in bits, >=1.
REQ-002 SHALL have parameter DEPTH, default 2: number of register stages, >=0.
REQ-003 SHALL have parameter RESET_DATA, default 0: 1 = data registers cleared to 0 on reset; 0 = data registers not reset.
REQ-004 SHALL derive localparam CW = max(1, ceil(log2(DEPTH+1))) as the occupancy width.
REQ-005 SHALL have one clock and synchronous active-high reset: clk  input  1  clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 dataIn  input  WIDTH  upstream payload.
REQ-008 validIn  input  1  upstream payload valid.
REQ-009 readyIn  output  1  pipe accepts dataIn this cycle.
REQ-010 dataOut  output  WIDTH  payload of output stage.
REQ-011 validOut  output  1  output stage holds valid payload.
REQ-012 readyOut  input  1  downstream consumes dataOut this cycle.
REQ-013 flush  input  1  discard all held payloads.
REQ-014 occupancy  output  CW  number of valid stages.

Function
REQ-015 SHALL hold stages 0..DEPTH-1, each a WIDTH data register plus valid bit; stage 0 = input side, stage DEPTH-1 = output stage.
REQ-016 SHALL drive dataOut/validOut directly from stage DEPTH-1 registers (no combinational path from dataIn).
REQ-017 SHALL define accept[DEPTH-1] = !valid[DEPTH-1] | readyOut; accept[i] = !valid[i] | accept[i+1] for i<DEPTH-1.
REQ-018 SHALL drive readyIn = accept[0] & !flush; combinational readyOut->readyIn path is permitted (length DEPTH).
REQ-019 Stage i<DEPTH-1 SHALL load from stage i-1 (or dataIn for i=0) when accept[i]; valid[i] <= upstream valid (valid[i-1], or validIn & readyIn for i=0).
REQ-020 Output stage SHALL load from stage DEPTH-2 (dataIn if DEPTH=1) under the same rule.
REQ-021 Data registers SHALL be written only when accept[i] and incoming valid is 1; otherwise hold (no toggling on bubbles).
REQ-022 Bubbles SHALL collapse: a valid stage advances into an empty downstream stage even while readyOut=0.
REQ-023 Latency: payload accepted at edge N into empty pipe SHALL appear with validOut=1 after edge N+DEPTH-1... i.e. visible in cycle N+DEPTH when counting acceptance cycle as N.
REQ-024 Throughput SHALL be one payload/cycle when readyOut=1 continuously; payload order SHALL be preserved, no loss, no duplication.
REQ-025 occupancy SHALL equal the registered count of set valid bits, updated each edge: +1 on input transfer, -1 on output transfer, unchanged on both or neither.
REQ-026 flush=1 SHALL clear all valid bits and occupancy at the next edge; simultaneous validIn is dropped (readyIn=0); simultaneous output transfer still counts as delivered downstream.
REQ-027 DEPTH=0 SHALL be pure combinational pass-through: dataOut=dataIn, validOut=validIn&!flush, readyIn=readyOut&!flush, occupancy=0.
REQ-028 Full pipe (occupancy=DEPTH) with readyOut=0 SHALL give readyIn=0; with readyOut=1 readyIn=1 and in/out transfer in the same cycle.

Reset
REQ-029 rst=1 at an edge SHALL clear all valid bits and occupancy to 0 and take priority over flush and transfers; validOut=0 and readyIn=1 (DEPTH>0) in the following cycle.
REQ-030 With RESET_DATA=1 all data registers and dataOut SHALL be 0 after reset; with RESET_DATA=0 data content is don't-care while invalid.
REQ-031 Reset asserted mid-stream SHALL discard all in-flight payloads; none emerges after deassertion.

Verification (WIDTH=8, DEPTH=3 unless stated)
REQ-032 Reset: rst 2 cycles with validIn=1 -> validOut=0, occupancy=0, readyIn=1 after release; RESET_DATA=1 -> dataOut=0x00.
REQ-033 Stream: readyOut=1, push 0x11,0x22,0x33 in cycles 0-2 -> validOut in cycles 3-5 with 0x11,0x22,0x33, readyIn stays 1, occupancy peaks at 3.
REQ-034 Backpressure: readyOut=0, validIn=1 with 0xA0..0xA3 -> 0xA0-0xA2 accepted, readyIn=0, occupancy=3; raise readyOut -> 0xA3 accepted same cycle 0xA0 leaves, order preserved.
REQ-035 Bubble collapse: readyOut=0, push 0x01, idle 1 cycle, push 0x02 -> both move forward until occupancy=2 in stages 2 and 1, stage 0 empty, readyIn=1.
REQ-036 Flush: occupancy=2, flush=1 with validIn=1 data 0x55 -> next cycle occupancy=0, validOut=0; 0x55 never appears.
REQ-037 DEPTH=0: dataIn=0x3C validIn=1 readyOut=0 -> dataOut=0x3C, validOut=1, readyIn=0 same cycle.
